// File: rtl/jk_cmd_seq.sv
// jk_cmd_seq: command sequencer for a downstream negedge JK flip-flop.
// It buffers JK commands (hold/reset/set/toggle) in a FIFO. Each command
// drives j/k for a programmed number of negedge samples and then holds
// j=k=0 for one check cycle. During that cycle the modelled flop output
// is compared with the q feedback, and a mismatch sets a sticky error.
//
// Ports:
//   clk, rst          clock (posedge logic), async active-high reset
//   in_valid/in_ready command handshake; in_ready = (level < DEPTH)
//   in_op             00 hold, 01 reset, 10 set, 11 toggle
//   in_rep            negedge samples to apply (0 is treated as 1)
//   j, k              registered drive to the flop
//   q_fb              flop q feedback
//   exp_q             modelled flop q
//   err, err_clr      sticky mismatch flag and its clear
//   busy              FSM active or commands queued
//   level             FIFO occupancy
module jk_cmd_seq #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_op,
    input  logic [CNT_W-1:0]         in_rep,
    output logic                     j,
    output logic                     k,
    input  logic                     q_fb,
    output logic                     exp_q,
    output logic                     err,
    input  logic                     err_clr,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t             state;
    logic [1:0]         op_mem  [DEPTH];
    logic [CNT_W-1:0]   rep_mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [1:0]         op_r;
    logic [CNT_W-1:0]   rem_r;
    logic               fifo_ne;
    logic               push;
    logic               pop;
    logic [1:0]         head_op;
    logic [CNT_W-1:0]   head_rem;

    // Flop behaviour after one sample with the given command
    function automatic logic next_q(input logic [1:0] op, input logic q);
        case (op)
            2'b00:   return q;
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            default: return ~q;
        endcase
    endfunction

    assign fifo_ne  = (level != '0);
    assign in_ready = (level < LW'(DEPTH));
    assign push     = in_valid && in_ready;
    // Pop only when the FSM loads a command (from IDLE or at CHECK exit)
    assign pop      = fifo_ne && ((state == IDLE) || (state == CHECK));
    assign busy     = (state != IDLE) || fifo_ne;
    assign head_op  = op_mem[rd_ptr];
    assign head_rem = (rep_mem[rd_ptr] == '0) ? CNT_W'(1) : rep_mem[rd_ptr];

    // Command storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr]  <= in_op;
            rep_mem[wr_ptr] <= in_rep;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is 2^AW)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            level <= level + LW'(push) - LW'(pop);
        end
    end

    // Sequencer FSM with registered j/k, flop model and error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            op_r  <= '0;
            rem_r <= '0;
            j     <= 1'b0;
            k     <= 1'b0;
            exp_q <= 1'b0;
            err   <= 1'b0;
        end else begin
            // Clear first so a same-edge mismatch below wins
            if (err_clr) err <= 1'b0;

            case (state)
                IDLE: begin
                    j <= 1'b0;
                    k <= 1'b0;
                    if (fifo_ne) begin
                        op_r  <= head_op;
                        rem_r <= head_rem;
                        j     <= head_op[1];
                        k     <= head_op[0];
                        state <= DRIVE;
                    end
                end

                DRIVE: begin
                    // One negedge sample elapsed in this cycle
                    exp_q <= next_q(op_r, exp_q);
                    if (rem_r == CNT_W'(1)) begin
                        j     <= 1'b0;
                        k     <= 1'b0;
                        state <= CHECK;
                    end else begin
                        rem_r <= rem_r - CNT_W'(1);
                    end
                end

                CHECK: begin
                    if (q_fb != exp_q) err <= 1'b1;
                    if (fifo_ne) begin
                        op_r  <= head_op;
                        rem_r <= head_rem;
                        j     <= head_op[1];
                        k     <= head_op[0];
                        state <= DRIVE;
                    end else begin
                        j     <= 1'b0;
                        k     <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: begin
                    j     <= 1'b0;
                    k     <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
